load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 44 ++++
 rtl/load_store_unit_extend.sv | 29 ++
 rtl/load_store_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width codes, memory mask
// encodings, FSM state encoding and the latched request record.
package load_store_unit_pkg;

  // RISC-V load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory port access size encodings
  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // A halfword on an odd address or a word off a 4-byte boundary
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == MASK_H) && a[0]) || ((f3[1:0] == MASK_W) && (a != 2'b00));
  endfunction

  // Width codes that exist; unsigned variants only make sense for loads
  function automatic logic f3_legal(input logic [2:0] f3, input logic store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Byte-lane helper: drops a returned byte into its lane of the assembly
// buffer, picks the store byte for the current lane, and sign/zero extends
// the assembled halfword for misaligned loads.
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_idx,
  input  logic [31:0] acc,
  input  logic [7:0]  rbyte,
  input  logic [31:0] wdata,
  output logic [31:0] acc_next,
  output logic [31:0] result,
  output logic [7:0]  wbyte
);

  // Little-endian lane insert/select followed by width-dependent extension
  always_comb begin
    acc_next = acc;
    acc_next[{byte_idx, 3'b000} +: 8] = rbyte;
    wbyte = wdata[{byte_idx, 3'b000} +: 8];
    case (funct3)
      F3_H:    result = {{16{acc_next[15]}}, acc_next[15:0]};
      F3_HU:   result = {16'h0000, acc_next[15:0]};
      default: result = acc_next;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues either a single
// aligned memory access or a run of byte accesses for misaligned data,
// and answers with a one-cycle response pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int TIMEOUT          = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_good,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_mask,
  output logic        mem_sext,
  input  logic [31:0] mem_rdata
);

  // Counter only needs to reach TIMEOUT-1 before the stall is declared dead
  localparam int   TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic ALLOW = (ALLOW_MISALIGNED != 0);

  logic [1:0]    state;
  req_t          req_q;
  logic          split_q;
  logic [1:0]    byte_idx;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   acc_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          is_split;
  logic          illegal;
  logic [1:0]    last_idx;
  logic          last;
  logic [31:0]   acc_next;
  logic [31:0]   ext_result;
  logic [7:0]    wbyte;

  assign is_split = is_misaligned(req_funct3, req_addr[1:0]);
  assign illegal  = (req_load == req_store) || !f3_legal(req_funct3, req_store) ||
                    (is_split && !ALLOW);
  assign last_idx = (req_q.funct3[1:0] == MASK_W) ? 2'd3 : 2'd1;
  assign last     = (byte_idx == last_idx);

  lsu_extend u_extend (
    .funct3   (req_q.funct3),
    .byte_idx (byte_idx),
    .acc      (acc_q),
    .rbyte    (mem_rdata[7:0]),
    .wdata    (req_q.wdata),
    .acc_next (acc_next),
    .result   (ext_result),
    .wbyte    (wbyte)
  );

  // Outputs decode straight from registered state, so they cannot move during a stall
  assign req_ready  = (state == ST_IDLE);
  assign mem_valid  = (state == ST_ACCESS);
  assign mem_read   = mem_valid && req_q.load;
  assign mem_write  = mem_valid && req_q.store;
  assign mem_addr   = mem_valid ? (req_q.addr + {30'b0, byte_idx}) : 32'h0;
  assign mem_wdata  = !mem_valid ? 32'h0 : (split_q ? {24'h0, wbyte} : req_q.wdata);
  assign mem_mask   = (mem_valid && !split_q) ? req_q.funct3[1:0] : MASK_B;
  assign mem_sext   = mem_valid && !split_q && !req_q.funct3[2];
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

  // Request FSM: latch on accept, step through accesses, watch for stalls, respond
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      split_q  <= 1'b0;
      byte_idx <= 2'd0;
      tmo_cnt  <= '0;
      acc_q    <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q    <= '{load: req_load, store: req_store, funct3: req_funct3,
                          addr: req_addr, wdata: req_wdata};
            split_q  <= is_split;
            byte_idx <= 2'd0;
            tmo_cnt  <= '0;
            acc_q    <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= illegal;
            state    <= illegal ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_good) begin
            tmo_cnt <= '0;
            if (req_q.load) begin
              if (!split_q) begin
                rdata_q <= mem_rdata;
              end else begin
                acc_q <= acc_next;
                if (last) rdata_q <= ext_result;
              end
            end
            if (!split_q || last) state <= ST_RESP;
            else                  byte_idx <= byte_idx + 2'd1;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
